// File: rtl/mac_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mac_layer_sequencer
//
// Purpose:
//   Initiator side of the MAC run/start/size/done/out handshake. One
//   i_layer_start runs NUM_NEURONS dot products back to back, one MAC job per
//   neuron. Each 16-bit Q(16-FRAC_BITS).FRAC_BITS result is stored in an
//   output-layer register bank, which feeds the next layer's input.
//
// Configuration macro:
//   MAC_SEQ_RELU_EN  defined   : captured value is ReLU(mac_out), so negative
//                                results are stored as zero.
//                    undefined : captured value is mac_out unchanged, and the
//                                activation is applied downstream.
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst_n         synchronous active-low reset
//   i_layer_start   request one layer pass (sampled in IDLE only)
//   o_layer_busy    high in every state except IDLE
//   o_layer_done    one-cycle pulse at the end of a pass (normal or aborted)
//   o_err_timeout   sticky: a MAC job exceeded TIMEOUT_CYCLES
//   o_mac_run       MAC enable; low makes the MAC reload its address counter
//   o_mac_clear     MAC accumulator clear, high in LOAD
//   o_mac_start     WEIGHT_BASE + n*FAN_IN for the current neuron n
//   o_mac_size      constant FAN_IN
//   i_mac_done      MAC finished (level)
//   i_mac_out       MAC accumulated sum, valid while i_mac_done is high
//   o_neuron_out    result bank; neuron n occupies bits [16n+15:16n]
// -----------------------------------------------------------------------------
module mac_layer_sequencer #(
    parameter int NUM_NEURONS    = 2,
    parameter int FAN_IN         = 2,
    parameter int WEIGHT_BASE    = 0,
    parameter int FRAC_BITS      = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_layer_start,
    output logic                      o_layer_busy,
    output logic                      o_layer_done,
    output logic                      o_err_timeout,
    output logic                      o_mac_run,
    output logic                      o_mac_clear,
    output logic signed [31:0]        o_mac_start,
    output logic signed [31:0]        o_mac_size,
    input  logic                      i_mac_done,
    input  logic [15:0]               i_mac_out,
    output logic [16*NUM_NEURONS-1:0] o_neuron_out
);

    // Parameter sanity; FRAC_BITS only describes the data format.
    if (NUM_NEURONS < 1) begin : g_badNumNeurons
        $error("mac_layer_sequencer: NUM_NEURONS must be >= 1");
    end
    if (FAN_IN < 1) begin : g_badFanIn
        $error("mac_layer_sequencer: FAN_IN must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
        $error("mac_layer_sequencer: TIMEOUT_CYCLES must be >= 2");
    end
    if (FRAC_BITS < 0 || FRAC_BITS > 15) begin : g_badFracBits
        $error("mac_layer_sequencer: FRAC_BITS must be in 0..15");
    end

    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [NW-1:0]     LAST_N      = NW'(NUM_NEURONS - 1);
    localparam logic [CW-1:0]     TIMEOUT_END = CW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [31:0] BASE_S     = 32'(WEIGHT_BASE);
    localparam logic signed [31:0] FAN_IN_S   = 32'(FAN_IN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                      r_state;
    logic [NW-1:0]               r_n;
    logic [CW-1:0]               r_cnt;
    logic                        r_err;
    logic                        r_run;
    logic                        r_clear;
    logic                        r_busy;
    logic                        r_done;
    logic signed [31:0]          r_start;
    logic [16*NUM_NEURONS-1:0]   r_bank;

    state_t                      w_nextState;
    logic [NW-1:0]               w_nextN;
    logic [CW-1:0]               w_nextCnt;
    logic                        w_nextErr;
    logic                        w_nextRun;
    logic                        w_nextClear;
    logic                        w_nextBusy;
    logic                        w_nextDone;
    logic signed [31:0]          w_nIdx;
    logic signed [31:0]          w_nextStart;
    logic                        w_capture;
    logic [15:0]                 w_activated;

    // Activation applied to the MAC sum when it is captured.
`ifdef MAC_SEQ_RELU_EN
    assign w_activated = i_mac_out[15] ? 16'h0000 : i_mac_out;
`else
    assign w_activated = i_mac_out;
`endif

    assign w_capture   = (r_state == S_CAPTURE);
    assign w_nIdx      = 32'(w_nextN);
    assign w_nextStart = BASE_S + w_nIdx * FAN_IN_S;

    // Next-state logic. The timeout counter is shared by two waits: the
    // stuck-done wait in LOAD and the job itself in RUN. It is cleared on
    // every entry to LOAD and again on LOAD->RUN, so a MAC that never drops
    // done aborts the pass instead of hanging the sequencer, and the job in
    // RUN always gets the full TIMEOUT_CYCLES budget. In RUN, done is tested
    // before the timeout so a job finishing on the last allowed cycle is kept.
    always_comb begin
        w_nextState = r_state;
        w_nextN     = r_n;
        w_nextCnt   = r_cnt;
        w_nextErr   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (i_layer_start) begin
                    w_nextN     = '0;
                    w_nextCnt   = '0;
                    w_nextErr   = 1'b0;
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_mac_done) begin
                    if (r_cnt == TIMEOUT_END) begin
                        w_nextErr   = 1'b1;
                        w_nextState = S_DONE;
                    end else begin
                        w_nextCnt = r_cnt + CW'(1);
                    end
                end else begin
                    w_nextCnt   = '0;
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (i_mac_done) begin
                    w_nextState = S_CAPTURE;
                end else if (r_cnt == TIMEOUT_END) begin
                    w_nextErr   = 1'b1;
                    w_nextState = S_DONE;
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end
            S_CAPTURE: begin
                if (r_n == LAST_N) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextN     = r_n + NW'(1);
                    w_nextCnt   = '0;
                    w_nextState = S_LOAD;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Output values are decoded from the next state and then registered, so
    // every registered output lines up exactly with the state it belongs to.
    always_comb begin
        w_nextRun   = (w_nextState == S_RUN);
        w_nextClear = (w_nextState == S_LOAD);
        w_nextBusy  = (w_nextState != S_IDLE);
        w_nextDone  = (w_nextState == S_DONE);
    end

    // State, neuron index, timeout counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_run   <= 1'b0;
            r_clear <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_start <= BASE_S;
        end else begin
            r_state <= w_nextState;
            r_n     <= w_nextN;
            r_cnt   <= w_nextCnt;
            r_err   <= w_nextErr;
            r_run   <= w_nextRun;
            r_clear <= w_nextClear;
            r_busy  <= w_nextBusy;
            r_done  <= w_nextDone;
            r_start <= w_nextStart;
        end
    end

    // Result bank: only the slot of the neuron being captured changes, so an
    // aborted pass leaves the remaining slots with their earlier results.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bank <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (r_n == NW'(k)) begin
                    r_bank[16*k +: 16] <= w_activated;
                end
            end
        end
    end

    assign o_layer_busy  = r_busy;
    assign o_layer_done  = r_done;
    assign o_err_timeout = r_err;
    assign o_mac_run     = r_run;
    assign o_mac_clear   = r_clear;
    assign o_mac_start   = r_start;
    assign o_mac_size    = FAN_IN_S;
    assign o_neuron_out  = r_bank;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_layer_sequencer
//
// Purpose:
//   Self-checking bench for mac_layer_sequencer. A MAC unit model answers the
//   handshake. A pass-level model turns each accepted layer_start into a
//   timeline of expected per-cycle outputs, built from the per-neuron latency
//   rules, and a compare process checks the DUT against it on every cycle.
//   Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mac_layer_sequencer;

    localparam int NUM  = 2;
    localparam int FAN  = 2;
    localparam int BASE = 0;
    localparam int TOUT = 16;
    localparam int RUN_LEN = 4 * FAN + 1;

    logic                clk = 1'b0;
    logic                rstN = 1'b0;
    logic                layerStart = 1'b0;
    logic                macDone = 1'b0;
    logic [15:0]         macOut = 16'h0000;
    logic                layerBusy;
    logic                layerDone;
    logic                errTimeout;
    logic                macRun;
    logic                macClear;
    logic signed [31:0]  macStart;
    logic signed [31:0]  macSize;
    logic [16*NUM-1:0]   neuronOut;

    mac_layer_sequencer #(
        .NUM_NEURONS   (NUM),
        .FAN_IN        (FAN),
        .WEIGHT_BASE   (BASE),
        .FRAC_BITS     (12),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_layer_start(layerStart),
        .o_layer_busy (layerBusy),
        .o_layer_done (layerDone),
        .o_err_timeout(errTimeout),
        .o_mac_run    (macRun),
        .o_mac_clear  (macClear),
        .o_mac_start  (macStart),
        .o_mac_size   (macSize),
        .i_mac_done   (macDone),
        .i_mac_out    (macOut),
        .o_neuron_out (neuronOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               busy;
        logic               done;
        logic               run;
        logic               clear;
        logic               err;
        logic               checkStart;
        logic signed [31:0] start;
        logic [16*NUM-1:0]  bank;
    } cycleExp_t;

    cycleExp_t          schedule[$];
    cycleExp_t          cur;
    logic [16*NUM-1:0]  modelBank = '0;
    logic               modelErr = 1'b0;

    logic [15:0]        macValue [NUM];
    int                 holdAfterFall = 1;
    int                 noDoneNeuron = -1;

    int                 checkCount = 0;
    int                 passCount = 0;
    bit                 checkEnable = 1'b0;
    int                 layerDoneSeen = 0;

    // Activation expected in the result bank for a raw MAC sum.
    function automatic logic [15:0] act(input logic [15:0] x);
`ifdef MAC_SEQ_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    function automatic cycleExp_t mk(input logic busy, input logic done, input logic run,
                                     input logic clear, input logic err, input logic chk,
                                     input int start, input logic [16*NUM-1:0] bank);
        cycleExp_t e;
        e.busy       = busy;
        e.done       = done;
        e.run        = run;
        e.clear      = clear;
        e.err        = err;
        e.checkStart = chk;
        e.start      = start;
        e.bank       = bank;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected timeline of one pass: per neuron LOAD (1 cycle, or the
    // stuck-done hold length for later neurons), RUN (MAC latency or the
    // timeout budget), CAPTURE (1), then a single DONE cycle.
    task automatic buildPass();
        bit aborted = 1'b0;
        for (int n = 0; n < NUM && !aborted; n++) begin
            int loadLen;
            loadLen = (n == 0) ? 1 : holdAfterFall;
            for (int c = 0; c < loadLen; c++)
                schedule.push_back(mk(1, 0, 0, 1, 0, 1, BASE + n * FAN, modelBank));
            if (n == noDoneNeuron) begin
                for (int c = 0; c < TOUT; c++)
                    schedule.push_back(mk(1, 0, 1, 0, 0, 1, BASE + n * FAN, modelBank));
                schedule.push_back(mk(1, 1, 0, 0, 1, 0, 0, modelBank));
                modelErr = 1'b1;
                aborted  = 1'b1;
            end else begin
                for (int c = 0; c < RUN_LEN; c++)
                    schedule.push_back(mk(1, 0, 1, 0, 0, 1, BASE + n * FAN, modelBank));
                schedule.push_back(mk(1, 0, 0, 0, 0, 1, BASE + n * FAN, modelBank));
                modelBank[16*n +: 16] = act(macValue[n]);
            end
        end
        if (!aborted) begin
            schedule.push_back(mk(1, 1, 0, 0, 0, 0, 0, modelBank));
            modelErr = 1'b0;
        end
    endtask

    // Pass-level model: advances one expected cycle per clock edge.
    always @(posedge clk) begin
        if (!rstN) begin
            schedule.delete();
            modelBank = '0;
            modelErr  = 1'b0;
            cur = mk(0, 0, 0, 0, 0, 1, BASE, '0);
        end else begin
            if (schedule.size() == 0 && !cur.busy && layerStart)
                buildPass();
            if (schedule.size() > 0)
                cur = schedule.pop_front();
            else
                cur = mk(0, 0, 0, 0, modelErr, 0, 0, modelBank);
        end
    end

    // MAC unit model: done rises 4*size cycles after run rises and falls
    // holdAfterFall cycles after run falls; never rises for noDoneNeuron.
    int runCnt = 0;
    int fallCnt = 0;
    always @(posedge clk) begin
        int idx;
        #1;
        idx = (int'(macStart) - BASE) / FAN;
        if (idx < 0 || idx >= NUM) idx = 0;
        macOut = macValue[idx];
        if (macRun === 1'b1) begin
            runCnt++;
            fallCnt = 0;
            if (runCnt >= RUN_LEN && idx != noDoneNeuron) macDone = 1'b1;
        end else begin
            runCnt = 0;
            if (macDone) begin
                fallCnt++;
                if (fallCnt > holdAfterFall) macDone = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("layer_busy", layerBusy, cur.busy);
            checkOutput("layer_done", layerDone, cur.done);
            checkOutput("mac_run", macRun, cur.run);
            checkOutput("mac_clear", macClear, cur.clear);
            checkOutput("err_timeout", errTimeout, cur.err);
            checkOutput("neuron_out", neuronOut, cur.bank);
            checkOutput("mac_size", macSize, FAN);
            if (cur.checkStart) checkOutput("mac_start", macStart, cur.start);
            if (layerDone === 1'b1) layerDoneSeen++;
        end
    end

    // Runs one pass from a negedge: optional extra start at cycle midStartAt
    // and in the DONE cycle; reports cycles to layer_done.
    task automatic applyStimulus(input int midStartAt, input bit startInDone,
                                 output int latency);
        bit gotDone = 1'b0;
        layerStart = 1'b1;
        latency = 0;
        while (latency < 200 && !gotDone) begin
            @(negedge clk);
            latency++;
            layerStart = (latency == midStartAt);
            if (layerDone === 1'b1) gotDone = 1'b1;
        end
        layerStart = 1'b0;
        checkOutput("layer_done_within_budget", gotDone, 1'b1);
        if (gotDone && startInDone) begin
            layerStart = 1'b1;
            @(negedge clk);
            layerStart = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int doneBefore;
        longint maxStart;

        maxStart = longint'(BASE) + longint'(NUM - 1) * longint'(FAN);
        if (maxStart > 64'sd2147483647 || maxStart < -64'sd2147483648) begin
            $display("[TB] FAIL mac_start_range: got %0d, expected a 32-bit signed value", maxStart);
            $fatal(1, "[TB] mac_start overflow");
        end

        macValue[0] = 16'h1000;
        macValue[1] = 16'h0800;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkEnable = 1'b1;
        checkOutput("reset_neuron_out", neuronOut, 32'h0000_0000);
        checkOutput("reset_mac_start", macStart, BASE);
        checkOutput("reset_mac_size", macSize, 2);
        checkOutput("reset_busy", layerBusy, 1'b0);
        checkOutput("reset_err", errTimeout, 1'b0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);

        // 1: basic pass
        $display("[TB] scenario 1: basic pass");
        applyStimulus(0, 0, lat);
        checkOutput("s1_latency", lat, 23);
        @(negedge clk);
        checkOutput("s1_bank", neuronOut, 32'h0800_1000);
        checkOutput("s1_busy_after", layerBusy, 1'b0);
        repeat (3) @(negedge clk);

        // 2: negative result
        $display("[TB] scenario 2: negative result");
        macValue[0] = 16'hF000;
        macValue[1] = 16'h0123;
        applyStimulus(0, 0, lat);
        @(negedge clk);
`ifdef MAC_SEQ_RELU_EN
        checkOutput("s2_slot0", neuronOut[15:0], 16'h0000);
`else
        checkOutput("s2_slot0", neuronOut[15:0], 16'hF000);
`endif
        checkOutput("s2_slot1", neuronOut[31:16], 16'h0123);
        repeat (3) @(negedge clk);

        // 3: stuck done for 3 cycles into LOAD
        $display("[TB] scenario 3: stuck done");
        macValue[0] = 16'h1000;
        macValue[1] = 16'h0800;
        holdAfterFall = 4;
        applyStimulus(0, 0, lat);
        checkOutput("s3_latency", lat, 26);
        @(negedge clk);
        checkOutput("s3_bank", neuronOut, 32'h0800_1000);
        holdAfterFall = 1;
        repeat (3) @(negedge clk);

        // 4: timeout on neuron 1
        $display("[TB] scenario 4: timeout");
        macValue[0] = 16'h0444;
        macValue[1] = 16'h0555;
        noDoneNeuron = 1;
        applyStimulus(0, 0, lat);
        checkOutput("s4_latency", lat, 29);
        checkOutput("s4_err_in_done", errTimeout, 1'b1);
        @(negedge clk);
        checkOutput("s4_bank", neuronOut, 32'h0800_0444);
        checkOutput("s4_err_sticky", errTimeout, 1'b1);
        noDoneNeuron = -1;
        repeat (3) @(negedge clk);

        // 5: extra starts mid-pass and in DONE; start also clears err
        $display("[TB] scenario 5: starts during pass");
        macValue[0] = 16'h0111;
        macValue[1] = 16'h0222;
        doneBefore = layerDoneSeen;
        applyStimulus(5, 1, lat);
        checkOutput("s5_latency", lat, 23);
        repeat (30) @(negedge clk);
        checkOutput("s5_done_pulses", layerDoneSeen - doneBefore, 1);
        checkOutput("s5_err_cleared", errTimeout, 1'b0);
        checkOutput("s5_bank", neuronOut, 32'h0222_0111);
        checkOutput("s5_busy_after", layerBusy, 1'b0);

        // 6: reset during neuron 1's RUN
        $display("[TB] scenario 6: reset mid-run");
        macValue[0] = 16'h0333;
        macValue[1] = 16'h0666;
        doneBefore = layerDoneSeen;
        layerStart = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            layerStart = 1'b0;
        end
        checkOutput("s6_run_before_reset", macRun, 1'b1);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("s6_busy", layerBusy, 1'b0);
        checkOutput("s6_bank", neuronOut, 32'h0000_0000);
        checkOutput("s6_run", macRun, 1'b0);
        checkOutput("s6_err", errTimeout, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("s6_no_done", layerDoneSeen - doneBefore, 0);
        macValue[0] = 16'h1000;
        macValue[1] = 16'h0800;
        applyStimulus(0, 0, lat);
        checkOutput("s6_restart_latency", lat, 23);
        @(negedge clk);
        checkOutput("s6_restart_bank", neuronOut, 32'h0800_1000);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
